block_lock_fsm: RTL and testbench

- RX-side 64b/66b block synchroniser that sequences the gearbox via its slip input.
- Monitors the 2-bit sync header of each gearbox output block and declares block lock after a run of valid headers.
- While unlocked, issues single-cycle slip pulses to shift gearbox alignment.
- While locked, drops lock on excessive header errors (IEEE 802.3 Clause 49 lock state machine, simplified).

---
 rtl/block_lock_if.sv | 26 ++
 rtl/block_lock_fsm.sv | 121 ++++++++++++
 tb/tb_block_lock_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/block_lock_if.sv
// rtl/block_lock_if.sv - Gearbox-to-block-synchroniser header/slip/lock bundle.
interface block_lock_if #(
    parameter int INVALID_LIMIT = 16
);
    logic [1:0]                             i_header;
    logic                                   i_header_valid;
    logic                                   o_slip;
    logic                                   o_block_lock;
    logic [$clog2(INVALID_LIMIT+1)-1:0]     o_sh_invalid_cnt;

    modport master (
        output i_header,
        output i_header_valid,
        input  o_slip,
        input  o_block_lock,
        input  o_sh_invalid_cnt
    );

    modport slave (
        input  i_header,
        input  i_header_valid,
        output o_slip,
        output o_block_lock,
        output o_sh_invalid_cnt
    );
endinterface

// File: rtl/block_lock_fsm.sv
// rtl/block_lock_fsm.sv - 64b/66b sync-header block lock state machine driving gearbox slip.
module block_lock_fsm #(
    parameter int LOCK_COUNT    = 64,
    parameter int INVALID_LIMIT = 16,
    parameter int SLIP_WAIT     = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    block_lock_if.slave  bl
);
    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int INV_W  = $clog2(INVALID_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    generate
        if (LOCK_COUNT < 2 || INVALID_LIMIT < 1 || INVALID_LIMIT > LOCK_COUNT || SLIP_WAIT < 1) begin : g_bad_params
            $error("block_lock_fsm: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t              r_state;
    logic [SH_W-1:0]     r_sh_cnt;
    logic [INV_W-1:0]    r_invld_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_slip;
    logic                r_block_lock;

    logic                w_hdr_ok;
    logic [SH_W-1:0]     w_sh_next;
    logic [INV_W-1:0]    w_inv_next;
    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_sh_full;
    logic                w_inv_full;
    logic                w_wait_done;

    // A sync header is legal only when its two bits differ (01 or 10).
    assign w_hdr_ok    = bl.i_header[1] ^ bl.i_header[0];
    assign w_sh_next   = (r_sh_cnt == SH_W'(LOCK_COUNT)) ? r_sh_cnt : r_sh_cnt + SH_W'(1);
    assign w_inv_next  = (r_invld_cnt == INV_W'(INVALID_LIMIT)) ? r_invld_cnt : r_invld_cnt + INV_W'(1);
    assign w_wait_next = (r_wait_cnt == WAIT_W'(SLIP_WAIT)) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
    assign w_sh_full   = (w_sh_next == SH_W'(LOCK_COUNT));
    assign w_inv_full  = (w_inv_next == INV_W'(INVALID_LIMIT));
    assign w_wait_done = (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_UNLOCKED;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_slip       <= 1'b0;
            r_block_lock <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                ST_UNLOCKED: begin
                    if (bl.i_header_valid) begin
                        if (w_hdr_ok) begin
                            if (w_sh_full) begin
                                r_state      <= ST_LOCKED;
                                r_block_lock <= 1'b1;
                                r_sh_cnt     <= '0;
                                r_invld_cnt  <= '0;
                            end else begin
                                r_sh_cnt <= w_sh_next;
                            end
                        end else begin
                            r_slip     <= 1'b1;
                            r_sh_cnt   <= '0;
                            r_wait_cnt <= '0;
                            r_state    <= ST_SLIP_WAIT;
                        end
                    end
                end
                // Gearbox is realigning: headers are meaningless until the wait expires.
                ST_SLIP_WAIT: begin
                    if (w_wait_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_UNLOCKED;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end
                ST_LOCKED: begin
                    if (bl.i_header_valid) begin
                        if (!w_hdr_ok && w_inv_full) begin
                            r_block_lock <= 1'b0;
                            r_slip       <= 1'b1;
                            r_sh_cnt     <= '0;
                            r_invld_cnt  <= '0;
                            r_wait_cnt   <= '0;
                            r_state      <= ST_SLIP_WAIT;
                        end else if (w_sh_full) begin
                            r_sh_cnt    <= '0;
                            r_invld_cnt <= '0;
                        end else begin
                            r_sh_cnt <= w_sh_next;
                            if (!w_hdr_ok) begin
                                r_invld_cnt <= w_inv_next;
                            end
                        end
                    end
                end
                default: begin
                    r_state      <= ST_UNLOCKED;
                    r_block_lock <= 1'b0;
                end
            endcase
        end
    end

    assign bl.o_slip           = r_slip;
    assign bl.o_block_lock     = r_block_lock;
    assign bl.o_sh_invalid_cnt = r_invld_cnt;
endmodule

// File: tb/tb_block_lock_fsm.sv
// tb/tb_block_lock_fsm.sv - Self-checking bench for block_lock_fsm against a header-level model.
module tb_block_lock_fsm;
    localparam int LOCK_COUNT    = 64;
    localparam int INVALID_LIMIT = 16;
    localparam int SLIP_WAIT     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Model: lock status, pending slip, headers seen in run/window, invalids, ignore cycles left.
    int m_lock = 0;
    int m_slip = 0;
    int m_run  = 0;
    int m_inv  = 0;
    int m_wait = 0;

    always #5 clk = ~clk;

    block_lock_if #(.INVALID_LIMIT(INVALID_LIMIT)) bus ();

    block_lock_fsm #(
        .LOCK_COUNT   (LOCK_COUNT),
        .INVALID_LIMIT(INVALID_LIMIT),
        .SLIP_WAIT    (SLIP_WAIT)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bl     (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic hv, input logic [1:0] h);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        m_slip = 0;
        if (r) begin
            m_lock = 0; m_run = 0; m_inv = 0; m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (hv) begin
            if (m_lock == 0) begin
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_lock = 1; m_run = 0; m_inv = 0;
                    end
                end else begin
                    m_slip = 1; m_run = 0; m_wait = SLIP_WAIT;
                end
            end else begin
                m_run++;
                if (!good) m_inv++;
                if (m_inv == INVALID_LIMIT) begin
                    m_lock = 0; m_slip = 1; m_run = 0; m_inv = 0; m_wait = SLIP_WAIT;
                end else if (m_run == LOCK_COUNT) begin
                    m_run = 0; m_inv = 0;
                end
            end
        end
    endtask

    // One clock: drive, update model at the edge, compare just after it.
    task automatic step(input logic r, input logic hv, input logic [1:0] h);
        rst = r;
        bus.i_header_valid = hv;
        bus.i_header = h;
        @(posedge clk);
        model(r, hv, h);
        #1;
        chk("model_lock", int'(bus.o_block_lock), m_lock);
        chk("model_slip", int'(bus.o_slip), m_slip);
        chk("model_invcnt", int'(bus.o_sh_invalid_cnt), m_inv);
    endtask

    task automatic run_n(input int n, input logic hv, input logic [1:0] h);
        for (int i = 0; i < n; i++) step(1'b0, hv, h);
    endtask

    initial begin
        int pct;
        logic [1:0] hh;
        bus.i_header = 2'b01;
        bus.i_header_valid = 1'b0;

        // Reset state and straight 01 run to lock
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        chk("reset_lock", int'(bus.o_block_lock), 0);
        chk("reset_slip", int'(bus.o_slip), 0);
        chk("reset_inv", int'(bus.o_sh_invalid_cnt), 0);
        run_n(63, 1'b1, 2'b01);
        chk("run63_nolock", int'(bus.o_block_lock), 0);
        step(1'b0, 1'b1, 2'b01);
        chk("run64_lock", int'(bus.o_block_lock), 1);

        // 15 invalids in a window hold lock; 16 in the next drop it
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, (i % 4 == 1 && i < 60) ? 2'b00 : 2'b10);
            if (i == 57) chk("win_inv15", int'(bus.o_sh_invalid_cnt), 15);
        end
        chk("win_end_inv0", int'(bus.o_sh_invalid_cnt), 0);
        chk("win_end_lock", int'(bus.o_block_lock), 1);
        for (int i = 0; i < 62; i++) step(1'b0, 1'b1, (i % 4 == 1) ? 2'b11 : 2'b01);
        chk("inv16_unlock", int'(bus.o_block_lock), 0);
        chk("inv16_slip", int'(bus.o_slip), 1);
        step(1'b0, 1'b1, 2'b01);
        chk("inv16_slip_one", int'(bus.o_slip), 0);
        run_n(31, 1'b1, 2'b01);

        // Relock, then 16th invalid coincides with the 64th header of the window
        run_n(64, 1'b1, 2'b01);
        chk("relock", int'(bus.o_block_lock), 1);
        run_n(48, 1'b1, 2'b10);
        run_n(15, 1'b1, 2'b11);
        chk("edge_inv15", int'(bus.o_sh_invalid_cnt), 15);
        step(1'b0, 1'b1, 2'b00);
        chk("edge_unlock", int'(bus.o_block_lock), 0);
        chk("edge_slip", int'(bus.o_slip), 1);

        // Invalid at header 10 while unlocked; headers ignored during the wait
        step(1'b1, 1'b0, 2'b00);
        run_n(9, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b11);
        chk("h10_slip", int'(bus.o_slip), 1);
        for (int i = 0; i < SLIP_WAIT; i++) begin
            step(1'b0, 1'b1, 2'b11);
            chk("wait_noslip", int'(bus.o_slip), 0);
        end
        run_n(63, 1'b1, 2'b01);
        chk("h10_63_nolock", int'(bus.o_block_lock), 0);
        step(1'b0, 1'b1, 2'b01);
        chk("h10_64_lock", int'(bus.o_block_lock), 1);

        // Half-rate valid pattern; paused cycles carry garbage headers
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 128; i++) begin
            hh = 2'($urandom_range(0, 3));
            step(1'b0, (i % 2 == 0), (i % 2 == 0) ? 2'b10 : hh);
            if (i == 125) chk("half_125_nolock", int'(bus.o_block_lock), 0);
            if (i == 126) chk("half_126_lock", int'(bus.o_block_lock), 1);
        end

        // Reset during slip wait and during locked
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        run_n(5, 1'b1, 2'b01);
        step(1'b1, 1'b1, 2'b00);
        chk("rst_wait_slip", int'(bus.o_slip), 0);
        chk("rst_wait_lock", int'(bus.o_block_lock), 0);
        run_n(63, 1'b1, 2'b01);
        chk("rst_wait_63", int'(bus.o_block_lock), 0);
        step(1'b0, 1'b1, 2'b01);
        chk("rst_wait_64", int'(bus.o_block_lock), 1);
        run_n(3, 1'b1, 2'b00);
        chk("locked_inv3", int'(bus.o_sh_invalid_cnt), 3);
        step(1'b1, 1'b1, 2'b00);
        chk("rst_lock_lock", int'(bus.o_block_lock), 0);
        chk("rst_lock_inv", int'(bus.o_sh_invalid_cnt), 0);
        run_n(63, 1'b1, 2'b10);
        chk("rst_lock_63", int'(bus.o_block_lock), 0);
        step(1'b0, 1'b1, 2'b10);
        chk("rst_lock_64", int'(bus.o_block_lock), 1);

        // Random traffic with epoch-varying error density
        pct = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 250 == 0) pct = (i / 250) % 4 == 0 ? 0 : (i / 250) % 4 == 1 ? 1 : (i / 250) % 4 == 2 ? 8 : 30;
            if ($urandom_range(0, 99) < pct) hh = $urandom_range(0, 1) ? 2'b00 : 2'b11;
            else hh = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), hh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
